// File: rtl/prog_loader.sv
// prog_loader: host byte stream -> program memory writer.
// Receives a header byte N, then N big-endian instruction words, and writes them
// to consecutive program-memory addresses from 0. The core is held in reset
// (cpu_hold) until a complete image has been loaded successfully.
// Optional feature macro PROG_LOADER_CHECKSUM_EN: when defined, a trailing
// checksum byte (XOR of header and payload) is verified before releasing the core;
// when undefined, no checksum byte is expected and err is constant 0.
module prog_loader #(
    parameter int PC_WIDTH  = 8,
    parameter int IRWidth   = 16,
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_wr_en,
    output logic [PC_WIDTH-1:0]  mem_wr_adr,
    output logic [IRWidth-1:0]   mem_wr_data,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        S_CHK,
        S_ERR
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   count_q, count_d;
    logic [PC_WIDTH-1:0]    adr_q, adr_d;
    logic [IRWidth-1:0]     data_q, data_d;
    logic                   hold_q, hold_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DataWidth-1:0]   csum_q, csum_d;
    logic                   err_q, err_d;
`endif

    // Next-state and Moore outputs derived from the current state.
    // NOTE: every _d and output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        adr_d     = adr_q;
        data_d    = data_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        err_d     = err_q;
`endif
        in_ready  = 1'b0;
        mem_wr_en = 1'b0;

        case (state_q)
            S_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = in_data;
`endif
                    if (in_data == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d[IRWidth-1:DataWidth] = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d[DataWidth-1:0] = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Write strobe lasts exactly this one cycle with the current adr/data.
                mem_wr_en = 1'b1;
                adr_d     = adr_q + PC_WIDTH'(1);
                count_d   = count_q - DataWidth'(1);
                if (count_q == DataWidth'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                // IDLE, DONE and ERR: wait for a start pulse to begin a fresh load.
                if (start) begin
                    state_d = S_HDR;
                    done_d  = 1'b0;
                    adr_d   = '0;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                end
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial image and holds the core.
    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from the values computed before the edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            count_q <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_wr_adr  = adr_q;
    assign mem_wr_data = data_q;
    assign cpu_hold    = hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a driver feeds byte images with random
// stalls; the expected memory writes are queued from the image and a monitor
// compares every write strobe against the queue.
module tb_prog_loader;

    localparam int PCW = 8;
    localparam int IRW = 16;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           res;
    logic           start;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic           mem_wr_en;
    logic [PCW-1:0] mem_wr_adr;
    logic [IRW-1:0] mem_wr_data;
    logic           cpu_hold;
    logic           busy;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    prog_loader #(.PC_WIDTH(PCW), .IRWidth(IRW), .DataWidth(DW)) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_adr (mem_wr_adr),
        .mem_wr_data(mem_wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [PCW-1:0] adr;
        logic [IRW-1:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         sb[$];
    wr_t         exp_wr;
    logic [7:0]  img[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next queued expected write.
    always @(negedge clk) begin
        if (!res && mem_wr_en) begin
            check("in_ready_low_in_write", in_ready, 0);
            check("write_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_wr = sb.pop_front();
                check("wr_adr", mem_wr_adr, exp_wr.adr);
                check("wr_data", mem_wr_data, exp_wr.data);
            end
        end
    end

    // Drive one byte (entered just after a negedge) and return after it is accepted.
    task automatic send_byte(input logic [7:0] b, input int max_stall, input bit noise);
        int st;
        bit ok;
        st = $urandom_range(0, max_stall);
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (st) begin
            start = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("byte_accepted", ok, 1);
    endtask

    // Pulse start, stream the current image, then check the final status.
    task automatic run_load(input bit valid_with_start, input int max_stall, input bit noise);
        int         n;
        int         k;
        bit         ok;
        logic [7:0] x;
        n = int'(img[0]);
        for (int i = 0; i < n; i++)
            sb.push_back('{adr: PCW'(i), data: {img[1 + 2 * i], img[2 + 2 * i]}});

        @(negedge clk);
        start    = 1'b1;
        in_valid = valid_with_start;
        in_data  = 8'hFF;
        #1 check("ready_low_before_start", in_ready, 0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("err_cleared", err, 0);
        check("hold_after_start", cpu_hold, 1);
        check("adr_cleared", mem_wr_adr, 0);

        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], max_stall, noise);
            if (i >= 2 && i <= 2 * n && (i % 2) == 0)
                check("write_latency", mem_wr_en, 1);
        end

        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("finish_in_time", busy, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < img.size() - 1; i++) x = x ^ img[i];
        ok = (x == img[img.size() - 1]);
        check("done_latency", k, 0);
        check("final_done", done, ok);
        check("final_err", err, !ok);
        check("final_hold", cpu_hold, !ok);
`else
        x  = 8'h00;
        ok = 1'b1;
        check("done_latency", k, (n == 0) ? 0 : 1);
        check("final_done", done, 1);
        check("final_err", err, 0);
        check("final_hold", cpu_hold, 0);
`endif
        check("final_adr", mem_wr_adr, n);
        check("all_writes_seen", sb.size(), 0);
    endtask

    // Random image of n words; under checksum builds, the checksum is corrupted when !good.
    task automatic make_random(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        img.delete();
        img.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            img.push_back(b);
            x = x ^ b;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_adr", mem_wr_adr, 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        res = 1'b0;
        @(negedge clk);

        // Basic load, with in_valid high alongside start (byte must not be taken in IDLE).
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(8'h42);
`endif
        run_load(1'b1, 0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum, then a good image to confirm start clears err.
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_load(1'b0, 0, 1'b0);
        img = '{8'h00, 8'h01};
        run_load(1'b0, 0, 1'b0);
        img = '{8'h00, 8'h00};
        run_load(1'b0, 0, 1'b0);
`else
        img = '{8'h01, 8'hDE, 8'hAD};
        run_load(1'b0, 0, 1'b0);
        img = '{8'h00};
        run_load(1'b0, 0, 1'b0);
`endif

        // Backpressure with random stalls and ignored start pulses while busy.
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
        img.push_back(8'h42);
`endif
        run_load(1'b0, 2, 1'b1);

        // Reset mid-load after the high byte of word 1.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        res = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_hold", cpu_hold, 1);
        check("midrst_adr", mem_wr_adr, 0);
        check("midrst_wr_en", mem_wr_en, 0);
        sb.delete();
        @(negedge clk);
        res = 1'b0;
        run_load(1'b0, 1, 1'b0);

        // Randomized images.
        for (int r = 0; r < 8; r++) begin
            make_random($urandom_range(0, 8), $urandom_range(0, 3) != 0);
            run_load($urandom_range(0, 1) == 1, 2, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
